// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: operand forwarding, load-use/branch/HI-LO stall
// detection and MDU busy scoreboard for a five-stage MIPS pipeline.
//
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   rs_ID, rt_ID              - ID-stage source registers
//   rs_EX, rt_EX              - EX-stage source registers
//   branch_ID, useHiLo_ID     - ID instruction compares regs / touches HI-LO
//   mdu_start_EX              - mult/div issuing from EX this cycle
//   WriteReg_*, regWr_*       - destination register and write enable per stage
//   memToReg_EX, memToReg_MEM - load in that stage
//   ForwardAE/BE              - EX operand select (00 RF, 01 WB, 10 MEM)
//   ForwardAD/BD              - ID comparator select (1 = MEM ALU result)
//   StallF, StallD, FlushE    - PC hold, IF/ID hold, ID/EX bubble
//   mdu_busy, mdu_count       - MDU in flight, remaining busy cycles
//   stall_count               - saturating count of stalled cycles
module hazard_forward_unit #(
  parameter int unsigned AW      = 5,
  parameter int unsigned MDU_LAT = 32,
  parameter int unsigned CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs_ID,
  input  logic [AW-1:0] rt_ID,
  input  logic [AW-1:0] rs_EX,
  input  logic [AW-1:0] rt_EX,
  input  logic          branch_ID,
  input  logic          useHiLo_ID,
  input  logic          mdu_start_EX,
  input  logic [AW-1:0] WriteReg_EX,
  input  logic [AW-1:0] WriteReg_MEM,
  input  logic [AW-1:0] WriteReg_WB,
  input  logic          regWr_EX,
  input  logic          regWr_MEM,
  input  logic          regWr_WB,
  input  logic          memToReg_EX,
  input  logic          memToReg_MEM,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic          ForwardAD,
  output logic          ForwardBD,
  output logic          StallF,
  output logic          StallD,
  output logic          FlushE,
  output logic          mdu_busy,
  output logic [CW-1:0] mdu_count,
  output logic [31:0]   stall_count
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_t;

  mdu_state_t    state_q, state_nxt;
  logic [CW-1:0] mdu_cnt_q, mdu_cnt_nxt;
  logic [31:0]   stall_cnt_q, stall_cnt_nxt;

  logic lwstall, brstall, mdustall, stall;

  // Register r is produced by a stage writing it (never $0).
  function automatic logic match(input logic [AW-1:0] r,
                                 input logic [AW-1:0] wr,
                                 input logic          we);
    return (r != '0) && (r == wr) && we;
  endfunction

  // Forwarding selects and stall detection.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    lwstall   = 1'b0;
    brstall   = 1'b0;
    mdustall  = 1'b0;

    if (match(rs_EX, WriteReg_MEM, regWr_MEM))     ForwardAE = 2'b10;
    else if (match(rs_EX, WriteReg_WB, regWr_WB))  ForwardAE = 2'b01;

    if (match(rt_EX, WriteReg_MEM, regWr_MEM))     ForwardBE = 2'b10;
    else if (match(rt_EX, WriteReg_WB, regWr_WB))  ForwardBE = 2'b01;

    ForwardAD = match(rs_ID, WriteReg_MEM, regWr_MEM) && !memToReg_MEM;
    ForwardBD = match(rt_ID, WriteReg_MEM, regWr_MEM) && !memToReg_MEM;

    lwstall = memToReg_EX && (match(rs_ID, WriteReg_EX, regWr_EX) ||
                              match(rt_ID, WriteReg_EX, regWr_EX));

    // A branch compares in ID, so it waits on any EX writer and on MEM loads.
    brstall = branch_ID &&
              (match(rs_ID, WriteReg_EX, regWr_EX) ||
               match(rt_ID, WriteReg_EX, regWr_EX) ||
               (memToReg_MEM && (match(rs_ID, WriteReg_MEM, regWr_MEM) ||
                                 match(rt_ID, WriteReg_MEM, regWr_MEM))));

    mdustall = useHiLo_ID && ((state_q == BUSY) || mdu_start_EX);

    stall = (lwstall || brstall || mdustall) && !rst;

    if (rst) begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
    end
  end

  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;

  // MDU scoreboard and stall counter next-state.
  always_comb begin
    state_nxt     = state_q;
    mdu_cnt_nxt   = mdu_cnt_q;
    stall_cnt_nxt = stall_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (mdu_start_EX) begin
          state_nxt   = BUSY;
          mdu_cnt_nxt = CW'(MDU_LAT);
        end
      end
      BUSY: begin
        // A new issue restarts the latency window rather than queueing.
        if (mdu_start_EX) begin
          mdu_cnt_nxt = CW'(MDU_LAT);
        end else if (mdu_cnt_q == CW'(1)) begin
          state_nxt   = IDLE;
          mdu_cnt_nxt = '0;
        end else begin
          mdu_cnt_nxt = mdu_cnt_q - CW'(1);
        end
      end
      default: begin
        state_nxt   = IDLE;
        mdu_cnt_nxt = '0;
      end
    endcase

    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_nxt = stall_cnt_q + 32'd1;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mdu_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_nxt;
      mdu_cnt_q   <= mdu_cnt_nxt;
      stall_cnt_q <= stall_cnt_nxt;
    end
  end

  assign mdu_busy    = (state_q == BUSY);
  assign mdu_count   = mdu_cnt_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Testbench for hazard_forward_unit: directed scenarios plus random stimulus
// checked against a behavioural model of the forwarding/stall rules.
module tb_hazard_forward_unit;

  localparam int unsigned AW  = 5;
  localparam int unsigned LAT = 4;
  localparam int unsigned CW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs_ID, rt_ID, rs_EX, rt_EX;
  logic          branch_ID, useHiLo_ID, mdu_start_EX;
  logic [AW-1:0] WriteReg_EX, WriteReg_MEM, WriteReg_WB;
  logic          regWr_EX, regWr_MEM, regWr_WB;
  logic          memToReg_EX, memToReg_MEM;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          ForwardAD, ForwardBD;
  logic          StallF, StallD, FlushE;
  logic          mdu_busy;
  logic [CW-1:0] mdu_count;
  logic [31:0]   stall_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int          m_rem;
  logic [31:0] m_sc;

  always #5 clk = ~clk;

  hazard_forward_unit #(.AW(AW), .MDU_LAT(LAT), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .rs_EX(rs_EX), .rt_EX(rt_EX),
    .branch_ID(branch_ID), .useHiLo_ID(useHiLo_ID), .mdu_start_EX(mdu_start_EX),
    .WriteReg_EX(WriteReg_EX), .WriteReg_MEM(WriteReg_MEM), .WriteReg_WB(WriteReg_WB),
    .regWr_EX(regWr_EX), .regWr_MEM(regWr_MEM), .regWr_WB(regWr_WB),
    .memToReg_EX(memToReg_EX), .memToReg_MEM(memToReg_MEM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .mdu_busy(mdu_busy), .mdu_count(mdu_count), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  // "Stage writes register r" in plain terms.
  function automatic bit writes(int r, int wr, bit we);
    return we && r != 0 && r == wr;
  endfunction

  function automatic int exp_fwd_e(int r);
    if (writes(r, WriteReg_MEM, regWr_MEM)) return 2;
    if (writes(r, WriteReg_WB, regWr_WB))   return 1;
    return 0;
  endfunction

  function automatic bit exp_stall();
    bit ex_dep, mem_dep, lw, br, md;
    ex_dep  = writes(rs_ID, WriteReg_EX, regWr_EX) || writes(rt_ID, WriteReg_EX, regWr_EX);
    mem_dep = writes(rs_ID, WriteReg_MEM, regWr_MEM) || writes(rt_ID, WriteReg_MEM, regWr_MEM);
    lw = memToReg_EX && ex_dep;
    br = branch_ID && (ex_dep || (memToReg_MEM && mem_dep));
    md = useHiLo_ID && (m_rem > 0 || mdu_start_EX);
    return !rst && (lw || br || md);
  endfunction

  task automatic clear_inputs();
    rst = 0; rs_ID = 0; rt_ID = 0; rs_EX = 0; rt_EX = 0;
    branch_ID = 0; useHiLo_ID = 0; mdu_start_EX = 0;
    WriteReg_EX = 0; WriteReg_MEM = 0; WriteReg_WB = 0;
    regWr_EX = 0; regWr_MEM = 0; regWr_WB = 0;
    memToReg_EX = 0; memToReg_MEM = 0;
  endtask

  // Inputs already applied after a negedge: check, clock, advance the model.
  task automatic cycle();
    bit s;
    #1;
    s = exp_stall();
    chk("ForwardAE", 32'(ForwardAE), rst ? 0 : 32'(exp_fwd_e(rs_EX)));
    chk("ForwardBE", 32'(ForwardBE), rst ? 0 : 32'(exp_fwd_e(rt_EX)));
    chk("ForwardAD", 32'(ForwardAD), 32'(!rst && writes(rs_ID, WriteReg_MEM, regWr_MEM) && !memToReg_MEM));
    chk("ForwardBD", 32'(ForwardBD), 32'(!rst && writes(rt_ID, WriteReg_MEM, regWr_MEM) && !memToReg_MEM));
    chk("StallF", 32'(StallF), 32'(s));
    chk("StallD", 32'(StallD), 32'(s));
    chk("FlushE", 32'(FlushE), 32'(s));
    chk("mdu_busy", 32'(mdu_busy), 32'(m_rem > 0));
    chk("mdu_count", 32'(mdu_count), 32'(m_rem));
    chk("stall_count", stall_count, m_sc);
    @(posedge clk);
    if (rst) begin
      m_rem = 0;
      m_sc  = 0;
    end else begin
      if (mdu_start_EX) m_rem = LAT;
      else if (m_rem > 0) m_rem = m_rem - 1;
      if (s && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
    end
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    m_rem = 0;
    m_sc  = 0;
    @(posedge clk);
    @(negedge clk);
    cycle();                      // still in reset, registers already cleared
    rst = 0;
    cycle();

    // EX forwarding priority
    rs_EX = 5; WriteReg_MEM = 5; regWr_MEM = 1; WriteReg_WB = 5; regWr_WB = 1;
    #1 chk("fae_mem", 32'(ForwardAE), 2);
    cycle();
    regWr_MEM = 0;
    #1 chk("fae_wb", 32'(ForwardAE), 1);
    cycle();
    rs_EX = 0;
    #1 chk("fae_zero", 32'(ForwardAE), 0);
    cycle();

    // Load-use stall
    clear_inputs();
    memToReg_EX = 1; regWr_EX = 1; WriteReg_EX = 8; rt_ID = 8;
    #1 chk("lw_stall", 32'(StallD), 1);
    cycle();
    chk("lw_count", stall_count, 1);
    WriteReg_EX = 0;
    #1 chk("lw_r0", 32'(StallD), 0);
    cycle();

    // Branch in ID
    clear_inputs();
    branch_ID = 1; rs_ID = 3; WriteReg_EX = 3; regWr_EX = 1;
    #1 chk("br_ex", 32'(StallF), 1);
    cycle();
    regWr_EX = 0; WriteReg_MEM = 3; regWr_MEM = 1;
    #1 chk("br_mem_alu", 32'(StallF), 0);
    chk("br_fad", 32'(ForwardAD), 1);
    cycle();
    memToReg_MEM = 1;
    #1 chk("br_mem_ld", 32'(StallF), 1);
    chk("br_fad_ld", 32'(ForwardAD), 0);
    cycle();

    // MDU latency window with a HI/LO consumer waiting
    clear_inputs();
    useHiLo_ID = 1; mdu_start_EX = 1;
    cycle();
    mdu_start_EX = 0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("mdu_seq", 32'(mdu_count), 32'(LAT - i));
      chk("mdu_stall", 32'(StallD), 32'(i < 4));
      cycle();
    end

    // Restart at count 2, then abort by reset
    mdu_start_EX = 1;
    cycle();
    mdu_start_EX = 0;
    cycle();
    cycle();
    #1 chk("rs_cnt2", 32'(mdu_count), 2);
    mdu_start_EX = 1;
    cycle();
    mdu_start_EX = 0;
    #1 chk("rs_reload", 32'(mdu_count), 4);
    rst = 1;
    #1 chk("rst_nostall", 32'(StallF), 0);
    cycle();
    rst = 0;
    #1 chk("rst_busy", 32'(mdu_busy), 0);
    chk("rst_sc", stall_count, 0);
    cycle();

    // Saturation
    clear_inputs();
    memToReg_EX = 1; regWr_EX = 1; WriteReg_EX = 9; rs_ID = 9;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    m_sc = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) cycle();
    chk("sat", stall_count, 32'hFFFF_FFFF);
    clear_inputs();
    cycle();

    // Random traffic over a small register space to provoke matches
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 63) == 0);
      rs_ID        = AW'($urandom_range(0, 3));
      rt_ID        = AW'($urandom_range(0, 3));
      rs_EX        = AW'($urandom_range(0, 3));
      rt_EX        = AW'($urandom_range(0, 3));
      WriteReg_EX  = AW'($urandom_range(0, 3));
      WriteReg_MEM = AW'($urandom_range(0, 3));
      WriteReg_WB  = AW'($urandom_range(0, 3));
      regWr_EX     = 1'($urandom_range(0, 1));
      regWr_MEM    = 1'($urandom_range(0, 1));
      regWr_WB     = 1'($urandom_range(0, 1));
      memToReg_EX  = 1'($urandom_range(0, 1));
      memToReg_MEM = 1'($urandom_range(0, 1));
      branch_ID    = 1'($urandom_range(0, 1));
      useHiLo_ID   = 1'($urandom_range(0, 1));
      mdu_start_EX = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
